// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the logic that feeds it.
//   - ALU command encodings (4-bit)
//   - NZCV bit positions within the 4-bit status word
//   - Request bundle type and round-robin priority type used by
//     alu_share_arbiter / rr_arbiter2
// Optional build macro used by the importing files: ALU_LOCK_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef logic [3:0]  alu_cmd_t;
   typedef logic [3:0]  nzcv_t;
   typedef logic [31:0] word_t;

   // ALU command encodings
   localparam alu_cmd_t ALU_NOP = 4'b0000;
   localparam alu_cmd_t ALU_MOV = 4'b0001;
   localparam alu_cmd_t ALU_MVN = 4'b1001;
   localparam alu_cmd_t ALU_ADD = 4'b0010;
   localparam alu_cmd_t ALU_ADC = 4'b0011;
   localparam alu_cmd_t ALU_SUB = 4'b0100;
   localparam alu_cmd_t ALU_SBC = 4'b0101;
   localparam alu_cmd_t ALU_AND = 4'b0110;
   localparam alu_cmd_t ALU_ORR = 4'b0111;
   localparam alu_cmd_t ALU_EOR = 4'b1000;

   // NZCV bit indices
   localparam int unsigned NZCV_N = 3;
   localparam int unsigned NZCV_Z = 2;
   localparam int unsigned NZCV_C = 1;
   localparam int unsigned NZCV_V = 0;

   // One requester's view of an ALU operation
   typedef struct packed {
      alu_cmd_t cmd;
      word_t    val1;
      word_t    val2;
      logic     s;
   } alu_req_t;

   // Which requester holds round-robin priority
   typedef enum logic {
      PRIO_R0 = 1'b0,
      PRIO_R1 = 1'b1
   } prio_t;

   function automatic prio_t prio_other(input prio_t p);
      return (p == PRIO_R0) ? PRIO_R1 : PRIO_R0;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant with a one-bit priority pointer.
// The pointer moves to the losing requester only on a contested grant.
// With ALU_LOCK_EN defined, a requester granted with its lock bit set keeps
// exclusive ownership until it is granted with lock clear or drops valid.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous, active-low reset
//   eligible  in   2  requester may be granted this cycle
//   valid     in   2  raw request valid (ALU_LOCK_EN only; releases a lock)
//   lock      in   2  request exclusive ownership (ALU_LOCK_EN only)
//   grant     out  2  one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arbiter2
   import alu_pkg::*;
#(
   parameter int unsigned PRIO_INIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] eligible,
`ifdef ALU_LOCK_EN
   input  logic [1:0] valid,
   input  logic [1:0] lock,
`endif
   output logic [1:0] grant
);

   localparam prio_t PTR_RESET = (PRIO_INIT != 0) ? PRIO_R1 : PRIO_R0;

   prio_t      ptr;
   prio_t      ptr_next;
   logic [1:0] cand;
   logic       contested;
   logic       hold;

`ifdef ALU_LOCK_EN
   logic  lock_held;
   prio_t owner;

   // Lock is only honoured while the owner keeps its request up.
   always_comb begin
      hold = lock_held & valid[owner];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_held <= 1'b0;
         owner     <= PRIO_R0;
      end else if (grant != 2'b00) begin
         lock_held <= lock[grant[1]];
         owner     <= grant[1] ? PRIO_R1 : PRIO_R0;
      end else if (lock_held && !valid[owner]) begin
         lock_held <= 1'b0;
      end
   end
`else
   always_comb begin
      hold = 1'b0;
   end
`endif

   // While held, only the owner is considered, even if its slot is full.
   always_comb begin
      cand = eligible;
`ifdef ALU_LOCK_EN
      if (hold) begin
         cand = eligible & ((owner == PRIO_R1) ? 2'b10 : 2'b01);
      end
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= PTR_RESET;
      end else begin
         ptr <= ptr_next;
      end
   end

   // Next-state
   always_comb begin
      ptr_next = ptr;
      if (contested && !hold) begin
         ptr_next = prio_other(ptr);
      end
   end

   // Output
   always_comb begin
      grant     = 2'b00;
      contested = 1'b0;
      case (cand)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11: begin
            contested = 1'b1;
            grant     = (ptr == PRIO_R1) ? 2'b10 : 2'b01;
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between the execute stage (requester 0) and
// the multi-cycle helper (requester 1). One operation per cycle, round-robin
// between contenders, one registered response slot per requester, and the
// architectural NZCV register whose carry feeds the ALU.
// Build macro: ALU_LOCK_EN adds req_lock for exclusive ALU ownership.
//
// Ports (per-requester buses packed {r1,r0}):
//   clk, rst         clock, asynchronous active-low reset
//   req_valid/ready  2     request handshake (ready = grant, same cycle)
//   req_cmd          2x4   ALU command
//   req_val1/val2    2x32  operands
//   req_s            2     commit NZCV to status
//   req_lock         2     hold ALU ownership (ALU_LOCK_EN only)
//   rsp_valid/ready  2     response handshake
//   rsp_res          2x32  registered result
//   rsp_status       2x4   NZCV produced by that operation
//   status           4     architectural NZCV
//   alu_command/status/val1/val2   to ALU
//   alu_res/alu_status_out         from ALU
// -----------------------------------------------------------------------------
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter logic [3:0]  STATUS_INIT = 4'b0000,
   parameter int unsigned PRIO_INIT   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [7:0]  req_cmd,
   input  logic [63:0] req_val1,
   input  logic [63:0] req_val2,
   input  logic [1:0]  req_s,
`ifdef ALU_LOCK_EN
   input  logic [1:0]  req_lock,
`endif
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [63:0] rsp_res,
   output logic [7:0]  rsp_status,
   output logic [3:0]  status,
   output logic [3:0]  alu_command,
   output logic [3:0]  alu_status,
   output logic [31:0] alu_val1,
   output logic [31:0] alu_val2,
   input  logic [31:0] alu_res,
   input  logic [3:0]  alu_status_out
);

   alu_req_t   req [2];
   logic [1:0] eligible;
   logic [1:0] grant;
   logic       granted;
   logic       sel;

   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         req[i].cmd  = req_cmd[i*4 +: 4];
         req[i].val1 = req_val1[i*32 +: 32];
         req[i].val2 = req_val2[i*32 +: 32];
         req[i].s    = req_s[i];
      end
   end

   // A slot being drained this cycle can be refilled on the same edge.
   always_comb begin
      eligible = req_valid & (~rsp_valid | rsp_ready);
   end

   rr_arbiter2 #(
      .PRIO_INIT (PRIO_INIT)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .eligible (eligible),
`ifdef ALU_LOCK_EN
      .valid    (req_valid),
      .lock     (req_lock),
`endif
      .grant    (grant)
   );

   always_comb begin
      granted   = |grant;
      sel       = grant[1];
      req_ready = grant & {2{rst}};
   end

   // ALU drive: granted requester's fields, or a zeroed NOP when idle.
   always_comb begin
      alu_command = ALU_NOP;
      alu_val1    = '0;
      alu_val2    = '0;
      if (granted) begin
         alu_command = req[sel].cmd;
         alu_val1    = req[sel].val1;
         alu_val2    = req[sel].val2;
      end
      alu_status = status;
   end

   // Response slots
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid  <= '0;
         rsp_res    <= '0;
         rsp_status <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            if (grant[i]) begin
               rsp_valid[i]          <= 1'b1;
               rsp_res[i*32 +: 32]   <= alu_res;
               rsp_status[i*4 +: 4]  <= alu_status_out;
            end else if (rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Architectural NZCV
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status <= STATUS_INIT;
      end else if (granted && req[sel].s) begin
         status <= alu_status_out;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
   import alu_pkg::*;

   localparam logic [3:0] TB_STATUS_INIT = 4'b0000;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [7:0]  req_cmd;
   logic [63:0] req_val1;
   logic [63:0] req_val2;
   logic [1:0]  req_s;
`ifdef ALU_LOCK_EN
   logic [1:0]  req_lock;
`endif
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [63:0] rsp_res;
   logic [7:0]  rsp_status;
   logic [3:0]  status;
   logic [3:0]  alu_command;
   logic [3:0]  alu_status;
   logic [31:0] alu_val1;
   logic [31:0] alu_val2;
   logic [31:0] alu_res;
   logic [3:0]  alu_status_out;

   int errors = 0;
   int checks = 0;

   logic [35:0] sbq0 [$];
   logic [35:0] sbq1 [$];
   logic [3:0]  model_status;
   logic [35:0] mon_exp;
   logic [35:0] mon_got;
   int          mon_g;

   alu_share_arbiter #(
      .STATUS_INIT (TB_STATUS_INIT),
      .PRIO_INIT   (0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_cmd        (req_cmd),
      .req_val1       (req_val1),
      .req_val2       (req_val2),
      .req_s          (req_s),
`ifdef ALU_LOCK_EN
      .req_lock       (req_lock),
`endif
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_res        (rsp_res),
      .rsp_status     (rsp_status),
      .status         (status),
      .alu_command    (alu_command),
      .alu_status     (alu_status),
      .alu_val1       (alu_val1),
      .alu_val2       (alu_val2),
      .alu_res        (alu_res),
      .alu_status_out (alu_status_out)
   );

   // Reference ALU: returns {NZCV, result}
   function automatic logic [35:0] alu_ref(input logic [3:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
      logic [32:0] sum;
      logic [31:0] r;
      logic        c;
      logic        v;
      sum = '0; r = '0; c = 1'b0; v = 1'b0;
      case (cmd)
         ALU_MOV: r = b;
         ALU_MVN: r = ~b;
         ALU_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            r = sum[31:0]; c = sum[32]; v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         ALU_ADC: begin
            sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            r = sum[31:0]; c = sum[32]; v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         ALU_SUB: begin
            sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = sum[31:0]; c = sum[32]; v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         ALU_SBC: begin
            sum = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
            r = sum[31:0]; c = sum[32]; v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         ALU_AND: r = a & b;
         ALU_ORR: r = a | b;
         ALU_EOR: r = a ^ b;
         default: return {4'b0100, 32'd0};
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   // The shared ALU itself lives outside the DUT
   always_comb begin
      {alu_status_out, alu_res} = alu_ref(alu_command, alu_val1, alu_val2, alu_status[NZCV_C]);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: sampled 1 time unit before each rising edge
   always begin
      @(negedge clk);
      #4;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               mon_got = {rsp_status[i*4 +: 4], rsp_res[i*32 +: 32]};
               checks++;
               if ((i == 0 && sbq0.size() == 0) || (i == 1 && sbq1.size() == 0)) begin
                  errors++;
                  $display("FAIL rsp_unexpected[%0d]: got %h want none", i, mon_got);
               end else begin
                  mon_exp = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
                  if (mon_got !== mon_exp) begin
                     errors++;
                     $display("FAIL rsp_data[%0d]: got %h want %h", i, mon_got, mon_exp);
                  end
               end
            end
         end
         checks++;
         if (status !== model_status) begin
            errors++;
            $display("FAIL status_track: got %b want %b", status, model_status);
         end
         checks++;
         if (alu_status !== model_status) begin
            errors++;
            $display("FAIL alu_status: got %b want %b", alu_status, model_status);
         end
         checks++;
         if (req_ready == 2'b11 || (req_ready & ~req_valid) != 2'b00) begin
            errors++;
            $display("FAIL grant_legal: got ready=%b valid=%b", req_ready, req_valid);
         end
         if (req_ready == 2'b00) begin
            checks++;
            if (alu_command !== 4'b0000 || alu_val1 !== 32'd0 || alu_val2 !== 32'd0) begin
               errors++;
               $display("FAIL alu_idle: got cmd=%b v1=%h v2=%h want 0", alu_command, alu_val1, alu_val2);
            end
         end else begin
            mon_g = req_ready[1] ? 1 : 0;
            mon_exp = alu_ref(req_cmd[mon_g*4 +: 4], req_val1[mon_g*32 +: 32],
                              req_val2[mon_g*32 +: 32], model_status[NZCV_C]);
            if (mon_g == 0) sbq0.push_back(mon_exp);
            else            sbq1.push_back(mon_exp);
            if (req_s[mon_g]) model_status = mon_exp[35:32];
         end
      end
   end

   task automatic drive_req(input int i, input logic [3:0] cmd, input logic [31:0] a,
                            input logic [31:0] b, input logic s);
      req_cmd[i*4 +: 4]   = cmd;
      req_val1[i*32 +: 32] = a;
      req_val2[i*32 +: 32] = b;
      req_s[i]            = s;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      req_valid = 2'b11; req_cmd = '0; req_val1 = '0; req_val2 = '0; req_s = '0;
      rsp_ready = 2'b00;
`ifdef ALU_LOCK_EN
      req_lock = 2'b00;
`endif
      model_status = TB_STATUS_INIT;
      #1;
      checks++;
      if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
      checks++;
      if (rsp_res !== 64'd0) begin errors++; $display("FAIL reset_rsp_res: got %h want 0", rsp_res); end
      checks++;
      if (rsp_status !== 8'd0) begin errors++; $display("FAIL reset_rsp_status: got %h want 0", rsp_status); end
      checks++;
      if (status !== TB_STATUS_INIT) begin errors++; $display("FAIL reset_status: got %b want %b", status, TB_STATUS_INIT); end
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      repeat (2) @(negedge clk);
      req_valid = 2'b00;
      rst = 1'b1;
   endtask

   task automatic test_single_add;
      @(negedge clk);
      drive_req(0, ALU_ADD, 32'd5, 32'd7, 1'b1);
      req_valid = 2'b01; rsp_ready = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL add_ready: got %b want 01", req_ready); end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL add_rsp_valid: got %b want 1", rsp_valid[0]); end
      checks++;
      if (rsp_res[31:0] !== 32'd12) begin errors++; $display("FAIL add_res: got %0d want 12", rsp_res[31:0]); end
      checks++;
      if (rsp_status[3:0] !== 4'b0000) begin errors++; $display("FAIL add_rsp_status: got %b want 0000", rsp_status[3:0]); end
      checks++;
      if (status !== 4'b0000) begin errors++; $display("FAIL add_status: got %b want 0000", status); end
      @(negedge clk);
      req_valid = 2'b00;
   endtask

   task automatic test_round_robin;
      logic [1:0] exp_g;
      exp_g = 2'b01;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         drive_req(0, ALU_ADD, k, k * 3, 1'b0);
         drive_req(1, ALU_EOR, k, 32'hA5A5_0000, 1'b0);
         req_valid = 2'b11; rsp_ready = 2'b11;
         #1;
         checks++;
         if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_g); end
         exp_g = {exp_g[0], exp_g[1]};
      end
      @(negedge clk);
      req_valid = 2'b00;
   endtask

   task automatic test_carry_chain;
      @(negedge clk);
      drive_req(0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
      req_valid = 2'b01; rsp_ready = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL adds_ready: got %b want 01", req_ready); end
      @(negedge clk);
      drive_req(0, ALU_ADC, 32'd0, 32'd0, 1'b0);
      #1;
      checks++;
      if (rsp_res[31:0] !== 32'd0) begin errors++; $display("FAIL adds_res: got %h want 0", rsp_res[31:0]); end
      checks++;
      if (rsp_status[3:0] !== 4'b0110) begin errors++; $display("FAIL adds_rsp_status: got %b want 0110", rsp_status[3:0]); end
      checks++;
      if (status !== 4'b0110) begin errors++; $display("FAIL adds_status: got %b want 0110", status); end
      @(posedge clk); #1;
      checks++;
      if (rsp_res[31:0] !== 32'd1) begin errors++; $display("FAIL adc_res: got %h want 1", rsp_res[31:0]); end
      @(negedge clk);
      req_valid = 2'b00;
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      drive_req(0, ALU_MOV, 32'd0, 32'd100, 1'b0);
      drive_req(1, ALU_SUB, 32'd3, 32'd5, 1'b0);
      req_valid = 2'b11; rsp_ready = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_first: got %b want 01", req_ready); end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_r1_issue: got %b want 10", req_ready); end
      @(posedge clk); #1;
      checks++;
      if (rsp_status[7:4] !== 4'b1000) begin errors++; $display("FAIL sub_rsp_status: got %b want 1000", rsp_status[7:4]); end
      checks++;
      if (status !== 4'b0110) begin errors++; $display("FAIL sub_status_hold: got %b want 0110", status); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive_req(0, ALU_MOV, 32'd0, 32'd200 + k, 1'b0);
         #1;
         checks++;
         if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_stall[%0d]: got %b want 01", k, req_ready); end
      end
      @(negedge clk);
      drive_req(1, ALU_ORR, 32'h0000_F0F0, 32'h0F00_000F, 1'b0);
      req_valid = 2'b10; rsp_ready = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_refill: got %b want 10", req_ready); end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_res[63:32] !== 32'h0F00_F0FF) begin
         errors++;
         $display("FAIL bp_refill_data: got v=%b res=%h want v=1 res=0f00f0ff", rsp_valid[1], rsp_res[63:32]);
      end
      @(negedge clk);
      req_valid = 2'b00;
   endtask

   task automatic test_undefined;
      @(negedge clk);
      drive_req(0, 4'b1111, 32'd123, 32'd456, 1'b1);
      req_valid = 2'b01; rsp_ready = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL undef_ready: got %b want 01", req_ready); end
      @(posedge clk); #1;
      checks++;
      if (rsp_res[31:0] !== 32'd0 || rsp_status[3:0] !== 4'b0100) begin
         errors++;
         $display("FAIL undef_rsp: got res=%h st=%b want 0 0100", rsp_res[31:0], rsp_status[3:0]);
      end
      checks++;
      if (status !== 4'b0100) begin errors++; $display("FAIL undef_status: got %b want 0100", status); end
      @(negedge clk);
      req_valid = 2'b00;
   endtask

   task automatic test_reset_midflight;
      @(negedge clk);
      drive_req(1, ALU_SUB, 32'd3, 32'd5, 1'b1);
      req_valid = 2'b10; rsp_ready = 2'b00;
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checks++;
      if (rsp_valid !== 2'b10 || status !== 4'b1000) begin
         errors++;
         $display("FAIL pending_before_reset: got v=%b st=%b want 10 1000", rsp_valid, status);
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 2'b00) begin errors++; $display("FAIL async_rsp_valid: got %b want 00", rsp_valid); end
      checks++;
      if (status !== TB_STATUS_INIT) begin errors++; $display("FAIL async_status: got %b want %b", status, TB_STATUS_INIT); end
      sbq0.delete();
      sbq1.delete();
      model_status = TB_STATUS_INIT;
      @(negedge clk);
      rst = 1'b1;
      rsp_ready = 2'b11;
      @(negedge clk);
      drive_req(0, ALU_MVN, 32'd0, 32'h2152_4110, 1'b0);
      req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_ready: got %b want 01", req_ready); end
      @(posedge clk); #1;
      checks++;
      if (rsp_res[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL post_reset_res: got %h want deadbeef", rsp_res[31:0]); end
      @(negedge clk);
      req_valid = 2'b00;
   endtask

`ifdef ALU_LOCK_EN
   task automatic test_lock;
      @(negedge clk);
      drive_req(0, ALU_ADD, 32'd1, 32'd2, 1'b0);
      drive_req(1, ALU_ADD, 32'd3, 32'd4, 1'b0);
      req_valid = 2'b11; rsp_ready = 2'b11; req_lock = 2'b01;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) req_lock = 2'b00;
         #1;
         checks++;
         if (req_ready !== 2'b01) begin errors++; $display("FAIL lock_hold[%0d]: got %b want 01", k, req_ready); end
         @(negedge clk);
      end
      #1;
      checks++;
      if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_release: got %b want 10", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
   endtask
`endif

   initial begin
      test_reset;
      test_single_add;
      test_round_robin;
      test_carry_chain;
      test_backpressure;
      test_undefined;
      test_reset_midflight;
`ifdef ALU_LOCK_EN
      test_lock;
`endif
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (sbq0.size() != 0 || sbq1.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", sbq0.size(), sbq1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the execute stage, port 1 is the multi-cycle helper (address and multiply-accumulate sequencer).
- Round-robin arbitration, one ALU operation per cycle, valid/ready handshakes on requests and responses.
- Owns the architectural NZCV status register; feeds its carry to the ALU and updates it on S-flagged operations.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- STATUS_INIT, 4'b0000: NZCV value loaded on reset.
- PRIO_INIT, 0: requester that holds priority after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester request accepted this cycle
- req_cmd  in  2x4  ALU command per requester (packed {r1,r0})
- req_val1  in  2x32  operand 1 per requester
- req_val2  in  2x32  operand 2 per requester
- req_s  in  2  update the status register when set
- rsp_valid  out  2  per-requester result valid
- rsp_ready  in  2  per-requester result consumed
- rsp_res  out  2x32  registered result per requester
- rsp_status  out  2x4  NZCV produced by that operation
- status  out  4  architectural NZCV register
- alu_command  out  4  to ALU
- alu_status  out  4  to ALU (always equals status)
- alu_val1  out  32  to ALU
- alu_val2  out  32  to ALU
- alu_res  in  32  from ALU
- alu_status_out  in  4  from ALU

Behaviour:
- Reset (async, rst=0): rsp_valid=0, rsp_res=0, rsp_status=0, status=STATUS_INIT, priority pointer=PRIO_INIT. req_ready is 0 while in reset.
- Eligibility: requester i is eligible when req_valid[i]=1 and its response slot is empty, or is being drained this cycle (rsp_valid[i] & rsp_ready[i]).
- Grant: at most one requester per cycle.
  - Single eligible requester wins.
  - Both eligible: the pointer holder wins; the pointer then moves to the other requester.
  - Pointer moves only on a contested grant.
- req_ready[i] = grant[i], combinational in the same cycle.
- ALU drive:
  - Granted: alu_command/val1/val2 are the granted requester's fields.
  - Idle: alu_command=4'b0000, operands 0.
- Latency: one cycle. On the grant edge, rsp_res[i] <= alu_res, rsp_status[i] <= alu_status_out, rsp_valid[i] <= 1.
- Response handshake: rsp_valid[i] clears on rsp_valid & rsp_ready unless a new grant to i occurs that same edge; then it stays 1 with new data.
- Response slot: each requester has one slot, holding at most one outstanding result.
- Status register: status <= alu_status_out on the grant edge when the granted req_s=1; otherwise it holds.
- Carry chains: back-to-back S-flagged ops (ADDS then ADC) see the updated carry on the next cycle.
- Non-S ops: never modify status.
- Undefined commands: the ALU returns 0 with z=1; this is still delivered as a response and still committed to status if s=1.
- Simultaneous drain and refill of the same slot: no bubble, full throughput.
- Reset mid-operation: in-flight results are discarded; requesters must reissue.

Optional Feature:
- Macro ALU_LOCK_EN.
- Enabled:
  - Adds input req_lock (2 bits).
  - A granted requester with req_lock=1 keeps exclusive ownership. The other requester is not granted until the owner completes a grant with req_lock=0, or deasserts req_valid.
  - The pointer does not move while the lock is held.
- Disabled: port absent; pure round-robin.

Decomposition:
- Shared package alu_pkg holds:
  - ALU command localparams: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
  - NZCV bit indices: N=3, Z=2, C=1, V=0.
- One natural sub-module: rr_arbiter2, holding the two-way round-robin grant and pointer logic, plus the lock logic when ALU_LOCK_EN is defined.

Test Plan:
- Only r0 valid: ADD 5+7, s=1 → req_ready[0]=1 in the same cycle; next cycle rsp_res[0]=12, rsp_status[0]=0000, status=0000.
- Both valid every cycle, PRIO_INIT=0, rsp_ready=1 → grants alternate 0,1,0,1 with no idle cycles.
- r0 ADDS 0xFFFFFFFF+1, then ADC 0+0 → first result 0 with status=0110 (Z, C); ADC result 1.
- r1 rsp_ready=0 with r1 request pending → r1 issues once, then req_ready[1]=0 while r0 keeps being granted; raising rsp_ready[1] allows r1's next grant in the same cycle as the drain.
- SUB 3-5 with s=0 → rsp_status[1]=1000; status unchanged.
- Assert rst with a pending response → rsp_valid=0 and status=STATUS_INIT immediately, without waiting for a clock edge.
